// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode and ALU select encodings for alu_issue_ctrl, plus the opcode-to-select decode.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_SLT  = 4'd2;
    localparam logic [3:0] OP_MUL  = 4'd3;
    localparam logic [3:0] OP_DIV  = 4'd4;
    localparam logic [3:0] OP_AND  = 4'd5;
    localparam logic [3:0] OP_OR   = 4'd6;
    localparam logic [3:0] OP_SHL1 = 4'd7;

    localparam logic [2:0] SEL_ADD  = 3'b000;
    localparam logic [2:0] SEL_SUB  = 3'b001;
    localparam logic [2:0] SEL_SLT  = 3'b010;
    localparam logic [2:0] SEL_MUL  = 3'b011;
    localparam logic [2:0] SEL_DIV  = 3'b100;
    localparam logic [2:0] SEL_AND  = 3'b101;
    localparam logic [2:0] SEL_OR   = 3'b110;
    localparam logic [2:0] SEL_SHL1 = 3'b111;

    // Opcodes 8-15 fall through to ADD; the trap build filters them before issue.
    function automatic logic [2:0] op_to_sel(input logic [3:0] op);
        logic [2:0] sel;
        case (op)
            OP_SUB:  sel = SEL_SUB;
            OP_SLT:  sel = SEL_SLT;
            OP_MUL:  sel = SEL_MUL;
            OP_DIV:  sel = SEL_DIV;
            OP_AND:  sel = SEL_AND;
            OP_OR:   sel = SEL_OR;
            OP_SHL1: sel = SEL_SHL1;
            default: sel = SEL_ADD;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/alu_rsp_fifo.sv
// rtl/alu_rsp_fifo.sv - synchronous response FIFO; head output is zero whenever the FIFO is empty.
module alu_rsp_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push_i,
    input  logic [W-1:0]                 push_data_i,
    input  logic                         pop_i,
    output logic                         valid_o,
    output logic [W-1:0]                 head_o,
    output logic [$clog2(DEPTH):0]       count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]    mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q, count_d;
    logic            do_push, do_pop;

    assign do_pop  = pop_i & (count_q != '0);
    assign do_push = push_i & ((count_q != CW'(DEPTH)) | do_pop);

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

    // Gating the head keeps the response fields at zero under reset without resetting storage.
    assign valid_o = (count_q != '0);
    assign head_o  = valid_o ? mem_q[rd_ptr_q] : '0;
    assign count_o = count_q;

endmodule

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - issues tagged requests to a combinational ALU and queues responses.
// Optional macro ALU_TRAP_EN: DIV by zero and illegal opcodes return an error response instead of issuing.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int TAG_W     = 4,
    parameter int RSP_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [TAG_W-1:0] req_tag,
    output logic [WIDTH-1:0] alu_op1,
    output logic [WIDTH-1:0] alu_op2,
    output logic [2:0]       alu_sel,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zflag,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_zero,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_err
);
    localparam int CW = $clog2(RSP_DEPTH) + 1;
    localparam int EW = WIDTH + TAG_W + 2;

    logic [WIDTH-1:0] op1_q, op1_d, op2_q, op2_d;
    logic [2:0]       sel_q, sel_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             exec_vld_q, exec_vld_d;
    logic             trap_q, trap_d, div0_q, div0_d;
    logic [CW-1:0]    fifo_count;
    logic             fifo_pop, accept, trap_req, div0_req;
    logic [EW-1:0]    push_data, head_data;
    logic [WIDTH-1:0] exec_data;
    logic             exec_zero;

    assign fifo_pop  = rsp_valid & rsp_ready;
    // Count the in-flight EXEC slot so an accepted request always has a FIFO entry waiting.
    assign req_ready = ((fifo_count + CW'(exec_vld_q)) < CW'(RSP_DEPTH)) | fifo_pop;
    assign accept    = req_valid & req_ready;

    assign div0_req = (req_op == OP_DIV) && (req_b == '0);
`ifdef ALU_TRAP_EN
    assign trap_req = div0_req || (req_op > OP_SHL1);
`else
    assign trap_req = 1'b0;
`endif

    always_comb begin
        op1_d      = op1_q;
        op2_d      = op2_q;
        sel_d      = sel_q;
        tag_d      = tag_q;
        trap_d     = trap_q;
        div0_d     = div0_q;
        exec_vld_d = accept;
        if (accept) begin
            tag_d  = req_tag;
            trap_d = trap_req;
            div0_d = div0_req;
            if (!trap_req) begin
                op1_d = req_a;
                op2_d = req_b;
                sel_d = op_to_sel(req_op);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op1_q      <= '0;
            op2_q      <= '0;
            sel_q      <= SEL_ADD;
            tag_q      <= '0;
            trap_q     <= 1'b0;
            div0_q     <= 1'b0;
            exec_vld_q <= 1'b0;
        end else begin
            op1_q      <= op1_d;
            op2_q      <= op2_d;
            sel_q      <= sel_d;
            tag_q      <= tag_d;
            trap_q     <= trap_d;
            div0_q     <= div0_d;
            exec_vld_q <= exec_vld_d;
        end
    end

    assign alu_op1 = op1_q;
    assign alu_op2 = op2_q;
    assign alu_sel = sel_q;

    assign exec_data = trap_q ? (div0_q ? {WIDTH{1'b1}} : '0) : alu_result;
    assign exec_zero = trap_q ? ~div0_q : ~alu_zflag;
    assign push_data = {trap_q, exec_zero, tag_q, exec_data};

    alu_rsp_fifo #(
        .W     (EW),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (exec_vld_q),
        .push_data_i (push_data),
        .pop_i       (fifo_pop),
        .valid_o     (rsp_valid),
        .head_o      (head_data),
        .count_o     (fifo_count)
    );

    assign {rsp_err, rsp_zero, rsp_tag, rsp_data} = head_data;

endmodule
